// File: rtl/seq_mult_hs.sv
// Shift-add serial multiplier with start/busy/done handshake; one multiplier bit per clock.
// Optional macro SEQ_MULT_SIGNED_EN enables two's-complement operation selected by tc.
module seq_mult_hs #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 tc,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PW-1:0]      r_mcand;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic               w_neg_step;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [PW-1:0]      w_addend;
    logic [PW-1:0]      w_acc_nxt;
    logic [PW-1:0]      w_mcand_ld;

    assign w_accept = (r_state != S_RUN) && start;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
    logic r_tc;

    function automatic logic [PW-1:0] extend_operand(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn) begin
            return {{WIDTH{v[WIDTH-1]}}, v};
        end else begin
            return {{WIDTH{1'b0}}, v};
        end
    endfunction

    assign w_mcand_ld = extend_operand(a, tc);
    // Multiplier MSB carries negative weight in signed mode: subtract on the last step.
    assign w_neg_step = r_tc && w_last;

    // Captured signedness of the operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc <= 1'b0;
        end else if (w_accept) begin
            r_tc <= tc;
        end else begin
            r_tc <= r_tc;
        end
    end
`else
    logic w_unused_tc;
    assign w_unused_tc = tc;
    assign w_mcand_ld  = {{WIDTH{1'b0}}, a};
    assign w_neg_step  = 1'b0;
`endif

    // One shift-add iteration of the accumulator.
    always_comb begin
        w_addend  = r_mplier[0] ? r_mcand : {PW{1'b0}};
        w_acc_nxt = r_acc;
        if (w_neg_step) begin
            w_acc_nxt = r_acc - w_addend;
        end else begin
            w_acc_nxt = r_acc + w_addend;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM output decode, taken from the next state so busy/done can be registered.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_RUN:   w_busy_nxt = 1'b1;
            S_DONE:  w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= {PW{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_acc    <= {PW{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_prod   <= {PW{1'b0}};
        end else if (w_accept) begin
            r_mcand  <= w_mcand_ld;
            r_mplier <= b;
            r_acc    <= {PW{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else if (r_state == S_RUN) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_prod <= w_acc_nxt;
            end else begin
                r_prod <= r_prod;
            end
        end else begin
            r_mcand  <= r_mcand;
            r_mplier <= r_mplier;
            r_acc    <= r_acc;
            r_cnt    <= r_cnt;
            r_prod   <= r_prod;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign prod = r_prod;

endmodule
